ex_div: RTL and testbench
=========================

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have port clk  in  1  core clock; all state updates on rising edge.
REQ-002 SHALL have port cpurst  in  1  reset, synchronous, active-low (0 = reset).
REQ-003 SHALL have port div_start  in  1  a divide/remainder op is in execute (decoded MD_OP & div class).
REQ-004 SHALL have port div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-005 SHALL have port div_oprand1  in  32  dividend, from the decode/execute register.
REQ-006 SHALL have port div_oprand2  in  32  divisor, from the decode/execute register.
REQ-007 SHALL have port div_flush  in  1  kill the in-flight op (exception/interrupt).
REQ-008 SHALL have port div_stall  out  1  hold the decode/execute register and upstream.
REQ-009 SHALL have port div_done  out  1  one-cycle pulse; div_result valid.
REQ-010 SHALL have port div_result  out  32  quotient or remainder per div_op.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 IDLE with div_start=1 and div_flush=0 SHALL latch operands, div_op and operand signs; |operands| for signed ops; 6-bit count=32.
REQ-013 From IDLE, a normal start SHALL go to CALC; a special case (REQ-018/019) SHALL go directly to DONE.
REQ-014 CALC SHALL perform one restoring shift-subtract step per cycle on a 33-bit partial remainder and decrement count; at count 1 -> DONE.
REQ-015 DONE SHALL assert div_done=1 and drive div_result; next state IDLE unconditionally; div_start is ignored in DONE.
REQ-016 Signed fix-up: quotient negated when operand signs differ; remainder takes the dividend sign; applied before DONE.
REQ-017 div_stall SHALL be combinational = (IDLE & div_start & ~div_flush) | CALC; it SHALL be 0 in DONE and whenever div_flush=1.
REQ-018 Divisor 0 SHALL give DIV/DIVU = 0xFFFFFFFF and REM/REMU = dividend.
REQ-019 DIV/REM with 0x80000000 / 0xFFFFFFFF SHALL give DIV = 0x80000000 and REM = 0.
REQ-020 Normal latency SHALL be: start cycle T; CALC T+1..T+32; DONE T+33, so div_stall=1 for 33 cycles. Special-case latency SHALL be: DONE at T+1.
REQ-021 div_result SHALL hold its value from DONE until the next DONE.
REQ-022 The next op MAY start in the IDLE cycle immediately after DONE, so back-to-back ops need no bubble.
REQ-023 div_flush=1 in any state SHALL force next state IDLE with no div_done pulse; div_result SHALL be unchanged.
REQ-024 If div_start and div_flush are both 1 in IDLE, the flush SHALL win: no op is started.
REQ-025 Operand changes after the start cycle SHALL have no effect on the in-flight op.

Reset
REQ-026 While cpurst=0 at a clock edge: state=IDLE, count=0, div_done=0, div_stall=0, div_result=0, internal registers cleared.
REQ-027 Reset SHALL take priority over div_start and div_flush; an op in progress during reset SHALL be abandoned with no div_done.

Verification
REQ-028 DIVU 100/7 -> div_stall=1 for 33 cycles; div_done at T+33 with div_result=14. REMU on the same operands -> 2.
REQ-029 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1). DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-030 DIVU 5/0 -> done at T+1 with 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> done at T+1 with 0x80000000.
REQ-031 div_flush at T+10 -> div_stall=0 that cycle, IDLE next, no div_done, div_result keeps its prior value.
REQ-032 cpurst=0 at T+5 during CALC -> all outputs 0 next cycle; a new DIVU 9/3 afterwards -> 3 at its own T+33.
REQ-033 Back-to-back: DIVU 10/3 then REMU 10/3 -> done pulses 34 cycles apart with results 3 and 1; no spurious done in between.

Source files
------------

// File: rtl/ex_div.sv
// ex_div: iterative 32-bit divide/remainder unit for the execute stage.
// It retires one quotient bit per cycle using restoring shift-subtract.
// Divide-by-zero and signed overflow finish one cycle after the start.
module ex_div (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        div_start,
  input  logic [1:0]  div_op,
  input  logic [31:0] div_oprand1,
  input  logic [31:0] div_oprand2,
  input  logic        div_flush,
  output logic        div_stall,
  output logic        div_done,
  output logic [31:0] div_result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_quot;     // holds the dividend and shifts quotient bits in from the bottom
  logic [32:0] r_rem;      // partial remainder
  logic [31:0] r_dvsr;
  logic [31:0] r_result;   // last delivered result, shown while not in DONE

  logic        w_signed;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic        w_div0;
  logic        w_ovf;
  logic        w_go;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_q_nxt;
  logic [31:0] w_r_nxt;
  logic [31:0] w_final;

  assign w_signed = ~div_op[0];
  assign w_a_abs  = (w_signed && div_oprand1[31]) ? (32'd0 - div_oprand1) : div_oprand1;
  assign w_b_abs  = (w_signed && div_oprand2[31]) ? (32'd0 - div_oprand2) : div_oprand2;
  assign w_div0   = (div_oprand2 == 32'd0);
  assign w_ovf    = w_signed && (div_oprand1 == 32'h8000_0000) && (div_oprand2 == 32'hFFFF_FFFF);
  assign w_go     = (r_state == S_IDLE) && div_start && !div_flush;

  // One restoring step. The remainder is always below the divisor, so the
  // shifted value fits in 33 bits and bit 32 of the difference is the borrow.
  assign w_shift  = {r_rem[31:0], r_quot[31]};
  assign w_diff   = w_shift - {1'b0, r_dvsr};
  assign w_ge     = ~w_diff[32];
  assign w_q_nxt  = {r_quot[30:0], w_ge};
  assign w_r_nxt  = w_ge ? w_diff[31:0] : w_shift[31:0];

  // r_quot and r_rem already carry the sign fix-up when DONE is entered.
  assign w_final  = r_op[1] ? r_rem[31:0] : r_quot;

  // Outputs are forced quiet during reset, and a flush kills them the same cycle.
  assign div_stall  = cpurst && !div_flush && (w_go || (r_state == S_CALC));
  assign div_done   = cpurst && !div_flush && (r_state == S_DONE);
  assign div_result = div_done ? w_final : r_result;

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!cpurst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_op     <= 2'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_quot   <= 32'd0;
      r_rem    <= 33'd0;
      r_dvsr   <= 32'd0;
      r_result <= 32'd0;
    end else if (div_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_start) begin
            r_op    <= div_op;
            r_neg_q <= w_signed && (div_oprand1[31] ^ div_oprand2[31]);
            r_neg_r <= w_signed && div_oprand1[31];
            r_dvsr  <= w_b_abs;
            r_cnt   <= 6'd32;
            if (w_div0) begin
              // The raw dividend is the remainder, whatever its sign.
              r_quot  <= 32'hFFFF_FFFF;
              r_rem   <= {1'b0, div_oprand1};
              r_state <= S_DONE;
            end else if (w_ovf) begin
              r_quot  <= 32'h8000_0000;
              r_rem   <= 33'd0;
              r_state <= S_DONE;
            end else begin
              r_quot  <= w_a_abs;
              r_rem   <= 33'd0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_quot  <= r_neg_q ? (32'd0 - w_q_nxt) : w_q_nxt;
            r_rem   <= {1'b0, r_neg_r ? (32'd0 - w_r_nxt) : w_r_nxt};
            r_state <= S_DONE;
          end else begin
            r_quot <= w_q_nxt;
            r_rem  <= {1'b0, w_r_nxt};
          end
        end
        S_DONE: begin
          r_result <= w_final;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed stimulus for ex_div. A latency and arithmetic model is
// checked against the outputs on every cycle, and literal results are checked per op.
module tb_ex_div;

  logic        clk;
  logic        cpurst;
  logic        div_start;
  logic [1:0]  div_op;
  logic [31:0] div_oprand1;
  logic [31:0] div_oprand2;
  logic        div_flush;
  logic        div_stall;
  logic        div_done;
  logic [31:0] div_result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ex_div dut (
    .clk(clk), .cpurst(cpurst), .div_start(div_start), .div_op(div_op),
    .div_oprand1(div_oprand1), .div_oprand2(div_oprand2), .div_flush(div_flush),
    .div_stall(div_stall), .div_done(div_done), .div_result(div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic, straight from the operation definitions.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Model: 0 idle, 1 busy (m_left cycles to go), 2 done.
  int          m_st = 0;
  int          m_left = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_result = '0;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (!cpurst) begin
      m_st     <= 0;
      m_result <= 32'd0;
    end else if (div_flush) begin
      m_st <= 0;
    end else begin
      case (m_st)
        0: if (div_start) begin
          m_pend <= ref_div(div_op, div_oprand1, div_oprand2);
          if (is_special(div_op, div_oprand1, div_oprand2)) m_st <= 2;
          else begin m_st <= 1; m_left <= 32; end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_st <= 2;
        end
        default: begin
          m_result <= m_pend;
          m_st     <= 0;
        end
      endcase
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    logic        e_stall;
    logic        e_done;
    logic [31:0] e_res;
    if (m_valid) begin
      e_stall = cpurst && !div_flush && ((m_st == 0 && div_start) || m_st == 1);
      e_done  = cpurst && !div_flush && (m_st == 2);
      e_res   = e_done ? m_pend : m_result;
      checks  = checks + 3;
      if (div_stall !== e_stall) begin
        errors = errors + 1;
        $display("FAIL model_stall cyc=%0d got %b want %b", cyc, div_stall, e_stall);
      end
      if (div_done !== e_done) begin
        errors = errors + 1;
        $display("FAIL model_done cyc=%0d got %b want %b", cyc, div_done, e_done);
      end
      if (div_result !== e_res) begin
        errors = errors + 1;
        $display("FAIL model_result cyc=%0d got %h want %h", cyc, div_result, e_res);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Start one op in cycle T, scramble operands afterwards, wait for done.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    @(posedge clk); #1;
    div_start = 1'b1; div_op = op; div_oprand1 = a; div_oprand2 = b;
    @(posedge clk); #1;
    div_start = 1'b0; div_oprand1 = $urandom; div_oprand2 = $urandom; div_op = 2'($urandom);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (div_done) begin n = i; break; end
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_result"}, div_result, exp);
  endtask

  initial begin
    int t1;
    int t2;
    cpurst = 1'b0; div_start = 1'b1; div_op = 2'b01; div_oprand1 = 32'd100;
    div_oprand2 = 32'd7; div_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", {31'd0, div_stall}, 32'd0);
    chk("reset_done", {31'd0, div_done}, 32'd0);
    chk("reset_result", div_result, 32'd0);
    @(posedge clk); #1;
    cpurst = 1'b1; div_start = 1'b0;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op("rem_m9_m4", 2'b10, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 33);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);

    // Flush at T+10: no done, result keeps 0xFFFFFFFF.
    @(posedge clk); #1;
    div_start = 1'b1; div_op = 2'b01; div_oprand1 = 32'd100; div_oprand2 = 32'd7;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (9) @(posedge clk);
    #1 div_flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, div_stall}, 32'd0);
    @(posedge clk); #1;
    div_flush = 1'b0;
    t1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_done) t1 = t1 + 1;
    end
    chk("flush_no_done", 32'(t1), 32'd0);
    chk("flush_result_held", div_result, 32'hFFFF_FFFF);

    // Reset at T+5 during CALC, then a fresh op.
    @(posedge clk); #1;
    div_start = 1'b1; div_op = 2'b01; div_oprand1 = 32'd100; div_oprand2 = 32'd7;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 cpurst = 1'b0;
    @(posedge clk); #1;
    cpurst = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall", {31'd0, div_stall}, 32'd0);
    chk("rst_mid_done", {31'd0, div_done}, 32'd0);
    chk("rst_mid_result", div_result, 32'd0);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

    // Back-to-back with start held high.
    @(posedge clk); #1;
    div_start = 1'b1; div_op = 2'b01; div_oprand1 = 32'd10; div_oprand2 = 32'd3;
    t1 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_done) begin t1 = cyc; break; end
    end
    chk("b2b_first", div_result, 32'd3);
    @(posedge clk); #1;
    div_op = 2'b11;
    @(posedge clk); #1;
    div_start = 1'b0;
    t2 = -1000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_done) begin t2 = cyc; break; end
    end
    chk("b2b_second", div_result, 32'd1);
    chk("b2b_spacing", 32'(t2 - t1), 32'd34);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
